// File: rtl/hack_mem_pkg.sv
// Shared constants and encodings for the Hack-style 4K RAM port and its DMA engine.
package hack_mem_pkg;

    localparam int AW = 12;
    localparam int DW = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        FILL  = 3'd3,
        DONE  = 3'd4
    } dma_state_t;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

endpackage

// File: rtl/ram_dma.sv
// Block copy / fill engine driving a single-port RAM with combinational read.
// The RAM port outputs are decodes of the state, base and counter registers.
module ram_dma #(
    parameter int AW = hack_mem_pkg::AW,
    parameter int DW = hack_mem_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_data,
    output logic          mem_load,
    input  logic [DW-1:0] mem_out
);

    import hack_mem_pkg::*;

    dma_state_t    state_r;
    dma_state_t    next_state_s;
    logic [AW-1:0] src_r;
    logic [AW-1:0] dst_r;
    logic [AW:0]   len_r;
    logic [DW-1:0] fill_r;
    logic [AW:0]   cnt_r;
    logic [AW:0]   cnt_inc_s;
    logic [DW-1:0] hold_r;
    logic [AW-1:0] src_adr_s;
    logic [AW-1:0] dst_adr_s;

    // Base + counter truncated to AW bits gives modulo-2^AW addressing.
    assign cnt_inc_s = cnt_r + {{AW{1'b0}}, 1'b1};
    assign src_adr_s = src_r + cnt_r[AW-1:0];
    assign dst_adr_s = dst_r + cnt_r[AW-1:0];

    // State, latched operands, word counter and read-hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            src_r   <= {AW{1'b0}};
            dst_r   <= {AW{1'b0}};
            len_r   <= {(AW+1){1'b0}};
            fill_r  <= {DW{1'b0}};
            cnt_r   <= {(AW+1){1'b0}};
            hold_r  <= {DW{1'b0}};
        end else begin
            state_r <= next_state_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        src_r  <= src;
                        dst_r  <= dst;
                        len_r  <= len;
                        fill_r <= fill_val;
                        cnt_r  <= {(AW+1){1'b0}};
                    end
                end
                READ:        hold_r <= mem_out;
                WRITE, FILL: cnt_r  <= cnt_inc_s;
                default:     ;
            endcase
        end
    end

    // Next-state and RAM-port decode.
    always_comb begin
        next_state_s = state_r;
        mem_adr      = {AW{1'b0}};
        mem_data     = {DW{1'b0}};
        mem_load     = 1'b0;
        busy         = (state_r != IDLE);
        done         = (state_r == DONE);
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len == {(AW+1){1'b0}}) begin
                        next_state_s = DONE;
                    end else if (op == OP_FILL) begin
                        next_state_s = FILL;
                    end else begin
                        next_state_s = READ;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ: begin
                mem_adr      = src_adr_s;
                next_state_s = WRITE;
            end
            WRITE, FILL: begin
                mem_adr  = dst_adr_s;
                mem_data = (state_r == FILL) ? fill_r : hold_r;
                // Suppress the strobe on a reset edge so an in-flight write never lands.
                mem_load = ~reset;
                if (cnt_inc_s == len_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = (state_r == FILL) ? FILL : READ;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

endmodule
